// File: rtl/bayer_demosaic_ctrl.sv
// bayer_demosaic_ctrl
// Frame/line sequencer for the RAW8 Bayer-to-RGB888 demosaic path. Follows
// the sensor vsync/href, produces per-pixel x/y coordinates and the Bayer
// phase select for the interpolation mux, and checks frame geometry against
// the configured resolution with sticky error flags.
//
// Ports
//   clk, rst_n               pixel clock, synchronous active-low reset
//   per_frame_vsync/href     sensor frame / line valid
//   cfg_bayer_pattern [1:0]  CFA start pattern (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR),
//                            latched at frame start
//   err_clr                  clears the sticky error flags (a set in the same
//                            cycle wins)
//   ctl_vsync, ctl_href      syncs delayed one cycle (href gated to ACTIVE)
//   pix_x, pix_y [10:0]      coordinates of the pixel qualified by ctl_href
//   phase_sel [1:0]          {row parity, col parity} ^ latched pattern
//   frame_start/line_end/frame_end  single-cycle event pulses
//   frame_cnt [15:0]         completed frames, wrapping
//   err_short_line/err_long_line/err_line_count  sticky geometry errors
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset; wait for vsync low so a partial frame is skipped
// S_ARMED  | wait for a vsync rising edge to start a frame
// S_ACTIVE | inside a frame: count pixels and lines, check geometry

module bayer_demosaic_ctrl #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic [1:0]  cfg_bayer_pattern,
  input  logic        err_clr,
  output logic        ctl_vsync,
  output logic        ctl_href,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [1:0]  phase_sel,
  output logic        frame_start,
  output logic        line_end,
  output logic        frame_end,
  output logic [15:0] frame_cnt,
  output logic        err_short_line,
  output logic        err_long_line,
  output logic        err_line_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;

  localparam logic [11:0] HDISP = {1'b0, IMG_HDISP};
  localparam logic [11:0] VDISP = {1'b0, IMG_VDISP};
  localparam logic [11:0] CMAX  = 12'hFFF;

  state_t      state_q, state_d;
  logic        vsync_q;
  logic        href_q, href_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] lcnt_q, lcnt_d;
  logic [11:0] lcnt_close;
  logic [10:0] pix_x_q, pix_x_d;
  logic [10:0] pix_y_q, pix_y_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  pat_q, pat_d;
  logic        fs_q, fs_d;
  logic        le_q, le_d;
  logic        fe_q, fe_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        es_q, es_d;
  logic        el_q, el_d;
  logic        ec_q, ec_d;
  logic        set_short, set_long, set_cnt;

  always_comb begin
    state_d    = state_q;
    href_d     = 1'b0;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    lcnt_close = lcnt_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    phase_d    = phase_q;
    pat_d      = pat_q;
    fs_d       = 1'b0;
    le_d       = 1'b0;
    fe_d       = 1'b0;
    fcnt_d     = fcnt_q;
    set_short  = 1'b0;
    set_long   = 1'b0;
    set_cnt    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!per_frame_vsync) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (per_frame_vsync && !vsync_q) begin
          state_d = S_ACTIVE;
          pat_d   = cfg_bayer_pattern;
          hcnt_d  = 12'd0;
          lcnt_d  = 12'd0;
          fs_d    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (per_frame_href) begin
          href_d  = 1'b1;
          pix_x_d = hcnt_q[10:0];
          pix_y_d = lcnt_q[10:0];
          phase_d = {lcnt_q[0], hcnt_q[0]} ^ pat_q;
          if (hcnt_q != CMAX) hcnt_d = hcnt_q + 12'd1;
        end else if (href_q) begin
          // href_q only rises inside ACTIVE, so this is a counted line closing
          set_short = (hcnt_q < HDISP);
          set_long  = (hcnt_q > HDISP);
          if (lcnt_q != CMAX) lcnt_close = lcnt_q + 12'd1;
          lcnt_d = lcnt_close;
          hcnt_d = 12'd0;
          le_d   = 1'b1;
        end
        if (vsync_q && !per_frame_vsync) begin
          // lcnt_close already includes a line closing in this same cycle
          set_cnt = (lcnt_close != VDISP);
          fcnt_d  = fcnt_q + 16'd1;
          fe_d    = 1'b1;
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    es_d = set_short | (es_q & ~err_clr);
    el_d = set_long  | (el_q & ~err_clr);
    ec_d = set_cnt   | (ec_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      hcnt_q  <= 12'd0;
      lcnt_q  <= 12'd0;
      pix_x_q <= 11'd0;
      pix_y_q <= 11'd0;
      phase_q <= 2'd0;
      pat_q   <= 2'd0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
      fe_q    <= 1'b0;
      fcnt_q  <= 16'd0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
      ec_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= per_frame_vsync;
      href_q  <= href_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
      fs_q    <= fs_d;
      le_q    <= le_d;
      fe_q    <= fe_d;
      fcnt_q  <= fcnt_d;
      es_q    <= es_d;
      el_q    <= el_d;
      ec_q    <= ec_d;
    end
  end

  assign ctl_vsync      = vsync_q;
  assign ctl_href       = href_q;
  assign pix_x          = pix_x_q;
  assign pix_y          = pix_y_q;
  assign phase_sel      = phase_q;
  assign frame_start    = fs_q;
  assign line_end       = le_q;
  assign frame_end      = fe_q;
  assign frame_cnt      = fcnt_q;
  assign err_short_line = es_q;
  assign err_long_line  = el_q;
  assign err_line_count = ec_q;

endmodule
